// File: rtl/snes_tap_pkg.sv
// Shared constants, header layout and serialiser states
// for the SNES bus tap.
package snes_tap_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hFF;

    // cfg_mode bits: bit0 captures writes, bit1 captures reads
    localparam logic [1:0] MODE_WR = 2'b01;
    localparam logic [1:0] MODE_RD = 2'b10;

    // Header byte layout: {seq[3:0], ovf, 0, rd, wr}
    localparam int HDR_WR_BIT  = 0;
    localparam int HDR_RD_BIT  = 1;
    localparam int HDR_OVF_BIT = 3;
    localparam int HDR_SEQ_LSB = 4;

    typedef enum logic [2:0] {
        SER_IDLE,
        SER_SYNC,
        SER_HDR,
        SER_MASK,
        SER_DATA,
        SER_ADDR
    } ser_state_e;

    function automatic logic [7:0] make_hdr(
        input logic [3:0] seq,
        input logic       ovf,
        input logic       rd
    );
        logic [7:0] h;
        h = '0;
        h[HDR_SEQ_LSB +: 4] = seq;
        h[HDR_OVF_BIT]      = ovf;
        h[HDR_RD_BIT]       = rd;
        h[HDR_WR_BIT]       = ~rd;
        return h;
    endfunction

    // Payload bytes equal to the sync byte go out as zero;
    // the mask byte tells the host which ones to restore.
    function automatic logic [7:0] esc_byte(input logic [7:0] b);
        return (b == SYNC_BYTE) ? 8'h00 : b;
    endfunction

endpackage

// File: rtl/snes_rec_fifo.sv
// Synchronous record queue with full/empty and fill level.
// Head entry stays visible until popped.
module snes_rec_fifo #(
    parameter  int W     = 18,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;

    assign level = wptr_q - rptr_q;
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign rdata = mem_q[rptr_q[AW-1:0]];

    // Next storage and pointer values for push/pop
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push && !full) begin
            mem_d[wptr_q[AW-1:0]] = wdata;
            wptr_d = wptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/snes_bus_tap.sv
// SNES bus sniffer: synchronise, qualify strobes, filter,
// queue records and serialise them as a framed byte stream.
module snes_bus_tap
    import snes_tap_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 3,
    parameter int FILT_LEN    = 3,
    parameter int REC_DEPTH   = 8,
    parameter int DROP_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              snes_rst_n,
    input  logic [ADDR_W-1:0] snes_addr,
    input  logic [7:0]        snes_data,
    input  logic              snes_rd_n,
    input  logic              snes_wr_n,
    input  logic              cfg_enable,
    input  logic [1:0]        cfg_mode,
    input  logic [ADDR_W-1:0] cfg_addr_lo,
    input  logic [ADDR_W-1:0] cfg_addr_hi,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DROP_W-1:0] drop_count,
    output logic              armed
);

    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int PAD_W      = ADDR_BYTES * 8;
    localparam int BUS_W      = ADDR_W + 8;
    localparam int SYNC_W     = 3 + BUS_W;
    localparam int REC_W      = 2 + BUS_W;
    localparam int CNT_W      = $clog2(FILT_LEN + 1);
    localparam int LVL_W      = $clog2(REC_DEPTH) + 1;
    localparam int IDX_W      = 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ADDR_BYTES - 1);

    // Synchroniser chain: {rst_n, rd_n, wr_n, addr, data}
    logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
    logic [SYNC_W-1:0] sync_d [SYNC_STAGES];
    logic              s_rst;
    logic [1:0]        s_stb;
    logic [BUS_W-1:0]  s_bus;

    // Strobe qualifier, index 0 = write, 1 = read
    logic [1:0]        qual_q, qual_d;
    logic [CNT_W-1:0]  fcnt_q [2];
    logic [CNT_W-1:0]  fcnt_d [2];
    logic [BUS_W-1:0]  hold_q [2];
    logic [BUS_W-1:0]  hold_d [2];
    logic [1:0]        commit;
    logic [1:0]        acc;
    logic [1:0]        win_ok;
    logic              armed_q, armed_d;

    // Push path
    logic              pend_q, pend_d;
    logic [BUS_W-1:0]  pend_bus_q, pend_bus_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              push_req;
    logic              push_rd;
    logic [BUS_W-1:0]  push_bus;
    logic              fifo_push;

    // Queue
    logic [REC_W-1:0]  fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_pop;

    // Serialiser
    ser_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        seq_q, seq_d;
    logic              h_ovf;
    logic              h_rd;
    logic [ADDR_W-1:0] h_addr;
    logic [7:0]        h_data;
    logic [PAD_W-1:0]  h_pad;
    logic [7:0]        abyte [ADDR_BYTES];
    logic [7:0]        abyte_sel;
    logic [7:0]        mask;

    assign s_rst = sync_q[SYNC_STAGES-1][SYNC_W-1];
    assign s_stb = sync_q[SYNC_STAGES-1][SYNC_W-2 -: 2];
    assign s_bus = sync_q[SYNC_STAGES-1][BUS_W-1:0];

    // Shift raw bus inputs through the synchroniser
    always_comb begin
        sync_d[0] = {snes_rst_n, snes_rd_n, snes_wr_n,
                     snes_addr, snes_data};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Glitch filter, bus hold, commit detect and arming
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            qual_d[i] = qual_q[i];
            fcnt_d[i] = '0;
            if (s_stb[i] != qual_q[i]) begin
                if (fcnt_q[i] == CNT_W'(FILT_LEN - 1)) begin
                    qual_d[i] = s_stb[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
            hold_d[i] = qual_q[i] ? hold_q[i] : s_bus;
            commit[i] = qual_d[i] & ~qual_q[i];
            win_ok[i] = (cfg_addr_lo <= hold_q[i][BUS_W-1:8])
                     && (hold_q[i][BUS_W-1:8] <= cfg_addr_hi);
        end
        acc[0] = commit[0] & armed_q & cfg_enable
               & (|(cfg_mode & MODE_WR)) & win_ok[0];
        acc[1] = commit[1] & armed_q & cfg_enable
               & (|(cfg_mode & MODE_RD)) & win_ok[1];
        armed_d = armed_q;
        if (!s_rst) begin
            armed_d = 1'b0;
        end else if (qual_q == 2'b11) begin
            armed_d = 1'b1;
        end
    end

    // Front-end registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int i = 0; i < 2; i++) begin
                fcnt_q[i] <= '0;
                hold_q[i] <= '0;
            end
            qual_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fcnt_q  <= fcnt_d;
            hold_q  <= hold_d;
            qual_q  <= qual_d;
            armed_q <= armed_d;
        end
    end

    // Pick one record per cycle; a coincident read waits a cycle
    always_comb begin
        pend_d     = pend_q;
        pend_bus_d = pend_bus_q;
        push_req   = 1'b0;
        push_rd    = 1'b0;
        push_bus   = hold_q[0];
        if (pend_q) begin
            push_req = 1'b1;
            push_rd  = 1'b1;
            push_bus = pend_bus_q;
            pend_d   = 1'b0;
        end else if (acc[0]) begin
            push_req = 1'b1;
            if (acc[1]) begin
                pend_d     = 1'b1;
                pend_bus_d = hold_q[1];
            end
        end else if (acc[1]) begin
            push_req = 1'b1;
            push_rd  = 1'b1;
            push_bus = hold_q[1];
        end
        drop_d    = drop_q;
        ovf_d     = ovf_q;
        fifo_push = 1'b0;
        if (push_req) begin
            if (fifo_full) begin
                ovf_d = 1'b1;
                if (drop_q != '1) begin
                    drop_d = drop_q + 1'b1;
                end
            end else begin
                fifo_push = 1'b1;
                ovf_d     = 1'b0;
            end
        end
    end

    // Push-path registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= 1'b0;
            pend_bus_q <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_bus_q <= pend_bus_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    snes_rec_fifo #(
        .W     (REC_W),
        .DEPTH (REC_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata ({ovf_q, push_rd, push_bus}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign h_ovf  = fifo_rdata[REC_W-1];
    assign h_rd   = fifo_rdata[REC_W-2];
    assign h_addr = fifo_rdata[BUS_W-1:8];
    assign h_data = fifo_rdata[7:0];
    assign h_pad  = PAD_W'(h_addr);

    // Split head address into MS-first bytes and build escape mask
    always_comb begin
        mask      = '0;
        mask[0]   = (h_data == SYNC_BYTE);
        abyte_sel = '0;
        for (int k = 0; k < ADDR_BYTES; k++) begin
            abyte[k]  = h_pad[(ADDR_BYTES-1-k)*8 +: 8];
            mask[k+1] = (abyte[k] == SYNC_BYTE);
            if (idx_q == IDX_W'(k)) begin
                abyte_sel = abyte[k];
            end
        end
    end

    // Serialiser state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SER_IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
        end
    end

    // Serialiser next state; head is popped on its last byte
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        seq_d    = seq_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            SER_IDLE: begin
                if (!fifo_empty) state_d = SER_SYNC;
            end
            SER_SYNC: begin
                if (out_ready) state_d = SER_HDR;
            end
            SER_HDR: begin
                if (out_ready) state_d = SER_MASK;
            end
            SER_MASK: begin
                if (out_ready) state_d = SER_DATA;
            end
            SER_DATA: begin
                if (out_ready) begin
                    state_d = SER_ADDR;
                    idx_d   = '0;
                end
            end
            SER_ADDR: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        fifo_pop = 1'b1;
                        seq_d    = seq_q + 1'b1;
                        idx_d    = '0;
                        state_d  = (fifo_level > LVL_W'(1))
                                 ? SER_SYNC : SER_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // Serialiser outputs
    always_comb begin
        out_valid = 1'b1;
        out_data  = '0;
        unique case (state_q)
            SER_IDLE: out_valid = 1'b0;
            SER_SYNC: out_data  = SYNC_BYTE;
            SER_HDR:  out_data  = make_hdr(seq_q, h_ovf, h_rd);
            SER_MASK: out_data  = mask;
            SER_DATA: out_data  = esc_byte(h_data);
            SER_ADDR: out_data  = esc_byte(abyte_sel);
            default:  out_valid = 1'b0;
        endcase
    end

    assign drop_count = drop_q;
    assign armed      = armed_q;

endmodule
